// File: rtl/job_sched_pkg.sv
// Shared types for the job scheduler: FSM states, job result codes and the
// error counter width with its saturating increment.
package job_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_CLEAR = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    RES_OK  = 2'd0,
    RES_ERR = 2'd1,
    RES_TMO = 2'd2
  } result_e;

  localparam int ERR_CNT_W = 8;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + ERR_CNT_W'(1);
  endfunction

endpackage

// File: rtl/job_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the first set req bit found searching
// upward from ptr+1 with wrap-around wins.
module rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [PW-1:0]    idx
);

  int          k;
  logic [PW-1:0] k_idx;
  logic        found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    k_idx = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      k     = (int'(ptr) + i) % N_REQ;
      k_idx = PW'(k);
      if (!found && req[k_idx]) begin
        found      = 1'b1;
        gnt[k_idx] = 1'b1;
        idx        = k_idx;
      end
    end
  end

endmodule

// File: rtl/job_scheduler.sv
// Shares one start/done/error control unit among N_REQ requesters: round-robin
// grant, start pulse, watchdog-guarded wait, completion pulse and unit clear.
module job_scheduler
  import job_sched_pkg::*;
#(
  parameter  int N_REQ   = 4,
  parameter  int TIMEOUT = 255,
  localparam int TW      = $clog2(TIMEOUT + 1),
  localparam int PW      = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req,
  output logic [N_REQ-1:0]     grant,
  output logic [N_REQ-1:0]     cpl,
  output logic                 cpl_err,
  output logic                 cpl_timeout,
  output logic                 unit_start,
  output logic                 unit_clr,
  input  logic                 unit_valid,
  input  logic                 unit_fault,
  output logic                 sched_busy,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [1:0]           dbg_state
);

  // Handshake: req is a level held by the requester until its one-cycle cpl
  // pulse; grant is held from START through CLEAR; unit_valid/unit_fault are
  // sticky unit status and are only looked at while in WAIT.

  state_e                 state_q, state_d;
  result_e                result_q, result_d;
  logic [N_REQ-1:0]       grant_q, grant_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic [N_REQ-1:0]       arb_gnt;
  logic [PW-1:0]          arb_idx;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req (req),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    timer_d   = timer_q;
    err_cnt_d = err_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          grant_d = arb_gnt;
          ptr_d   = arb_idx;
          state_d = ST_START;
        end
      end
      ST_START: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        timer_d = timer_q + TW'(1);
        // Fault outranks valid, and a real response outranks the watchdog.
        if (unit_fault) begin
          result_d = RES_ERR;
          state_d  = ST_CLEAR;
        end else if (unit_valid) begin
          result_d = RES_OK;
          state_d  = ST_CLEAR;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          result_d = RES_TMO;
          state_d  = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (result_q != RES_OK) err_cnt_d = sat_inc(err_cnt_q);
        grant_d = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      result_q  <= RES_OK;
      grant_q   <= '0;
      ptr_q     <= PW'(N_REQ - 1);
      timer_q   <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      timer_q   <= timer_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign grant       = grant_q;
  assign cpl         = (state_q == ST_CLEAR) ? grant_q : '0;
  assign cpl_err     = (state_q == ST_CLEAR) && (result_q == RES_ERR);
  assign cpl_timeout = (state_q == ST_CLEAR) && (result_q == RES_TMO);
  assign unit_start  = (state_q == ST_START);
  assign unit_clr    = (state_q == ST_CLEAR);
  assign sched_busy  = (state_q != ST_IDLE);
  assign err_cnt     = err_cnt_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_job_scheduler.sv
// Directed plus randomized bench for job_scheduler; the control unit's
// responses are driven per cycle and outcomes predicted from the scheduling rules.
module tb_job_scheduler;

  localparam int N_REQ   = 4;
  localparam int TIMEOUT = 8;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] cpl;
  logic             cpl_err;
  logic             cpl_timeout;
  logic             unit_start;
  logic             unit_clr;
  logic             unit_valid;
  logic             unit_fault;
  logic             sched_busy;
  logic [7:0]       err_cnt;
  logic [1:0]       dbg_state;

  job_scheduler #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .grant       (grant),
    .cpl         (cpl),
    .cpl_err     (cpl_err),
    .cpl_timeout (cpl_timeout),
    .unit_start  (unit_start),
    .unit_clr    (unit_clr),
    .unit_valid  (unit_valid),
    .unit_fault  (unit_fault),
    .sched_busy  (sched_busy),
    .err_cnt     (err_cnt),
    .dbg_state   (dbg_state)
  );

  // scoreboard
  int               tests = 0;
  int               fails = 0;
  logic [N_REQ-1:0] exp_q[$];
  int               exp_ptr;
  int               exp_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration: first pending requester after the last winner.
  function automatic int pick(input logic [N_REQ-1:0] r, input int p);
    for (int i = 1; i <= N_REQ; i++) begin
      if (r[(p + i) % N_REQ]) return (p + i) % N_REQ;
    end
    return 0;
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_cpl"}, cpl, 0);
    chk({tag, "_cpl_err"}, cpl_err, 0);
    chk({tag, "_cpl_tmo"}, cpl_timeout, 0);
    chk({tag, "_start"}, unit_start, 0);
    chk({tag, "_clr"}, unit_clr, 0);
    chk({tag, "_busy"}, sched_busy, 0);
    chk({tag, "_err_cnt"}, err_cnt, exp_err);
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    req        = '0;
    unit_valid = 1'b0;
    unit_fault = 1'b0;
    exp_ptr    = N_REQ - 1;
    exp_err    = 0;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;
  endtask

  // kind: 0 valid, 1 fault, 2 silent, 3 valid+fault; lat counts WAIT cycles.
  // Entered and left at a negedge with the scheduler idle.
  task automatic run_job(input logic [N_REQ-1:0] r, input int kind, input int lat, input bit drop);
    int               win;
    int               res_w;
    bit               responds;
    bit               exp_e;
    bit               exp_t;
    logic [N_REQ-1:0] exp_cpl;
    req      = r;
    win      = pick(r, exp_ptr);
    exp_ptr  = win;
    exp_q.push_back(N_REQ'(1) << win);
    responds = (kind != 2) && (lat <= TIMEOUT - 1);
    res_w    = responds ? lat : TIMEOUT - 1;
    exp_e    = responds && (kind == 1 || kind == 3);
    exp_t    = !responds;

    @(negedge clk);
    chk("start_grant", grant, N_REQ'(1) << win);
    chk("start_pulse", unit_start, 1);
    chk("start_busy", sched_busy, 1);
    chk("start_cpl", cpl, 0);

    for (int w = 0; w <= res_w; w++) begin
      @(negedge clk);
      if (w == 0 && drop) req = '0;
      chk("wait_cpl", cpl, 0);
      chk("wait_clr", unit_clr, 0);
      chk("wait_start", unit_start, 0);
      chk("wait_grant", grant, N_REQ'(1) << win);
      if (kind != 2 && w >= lat) begin
        unit_valid = (kind == 0 || kind == 3);
        unit_fault = (kind == 1 || kind == 3);
      end
    end

    @(negedge clk);
    unit_valid = 1'b0;
    unit_fault = 1'b0;
    exp_cpl    = exp_q.pop_front();
    chk("clear_cpl", cpl, exp_cpl);
    chk("clear_cpl_err", cpl_err, exp_e);
    chk("clear_cpl_tmo", cpl_timeout, exp_t);
    chk("clear_unit_clr", unit_clr, 1);
    chk("clear_grant", grant, exp_cpl);
    if ((exp_e || exp_t) && exp_err < 255) exp_err++;

    @(negedge clk);
    check_idle_outputs("idle");
  endtask

  initial begin
    req        = '0;
    unit_valid = 1'b0;
    unit_fault = 1'b0;
    reset      = 1'b1;
    @(negedge clk);
    do_reset();

    // single job: valid five cycles after start
    run_job(4'b0001, 0, 4, 1'b1);

    // round robin from reset with everybody pending
    do_reset();
    for (int i = 0; i < 5; i++) run_job(4'b1111, 0, $urandom_range(0, 3), 1'b0);
    req = '0;

    // fault, then a normal job
    run_job(4'b0010, 1, 2, 1'b0);
    run_job(4'b0100, 0, 1, 1'b0);

    // watchdog expiry, coincident valid+fault, valid on the timeout cycle
    run_job(4'b1000, 2, 0, 1'b0);
    run_job(4'b0001, 3, 3, 1'b0);
    run_job(4'b0010, 0, TIMEOUT - 1, 1'b0);
    req = '0;

    // randomized jobs
    for (int i = 0; i < 24; i++) begin
      run_job(N_REQ'($urandom_range(1, (1 << N_REQ) - 1)), $urandom_range(0, 3),
              $urandom_range(0, TIMEOUT + 2), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) req = '0;
    end

    // reset in the middle of WAIT aborts the job without a completion
    req = 4'b1111;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    reset   = 1'b1;
    exp_err = 0;
    exp_ptr = N_REQ - 1;
    exp_q.delete();
    @(negedge clk);
    check_idle_outputs("mid_reset");
    reset = 1'b0;
    run_job(4'b1111, 0, 2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/job_scheduler.md
# job_scheduler

Round-robin scheduler that shares a single start/done/error control unit among N_REQ requesters. It arbitrates requests, launches one job at a time and watches the unit's valid/fault status with a watchdog timer. It returns a per-requester completion pulse with status, then clears the unit's sticky DONE/ERROR state before it issues the next grant. It sits between the requesting engines and the control unit inside the subsystem.

## Interface
- N_REQ, 4: number of requesters, 2..16
- TIMEOUT, 255: maximum cycles in WAIT before a job is declared timed out, ≥2
- TW, $clog2(TIMEOUT+1): timer width (derived)
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req  in  N_REQ  level request per requester, held until its cpl pulse
- grant  out  N_REQ  one-hot owner of the unit, held from START through CLEAR
- cpl  out  N_REQ  one-cycle completion pulse to the granted requester
- cpl_err  out  1  qualifies cpl: unit reported fault
- cpl_timeout  out  1  qualifies cpl: watchdog expired
- unit_start  out  1  one-cycle start pulse to the control unit
- unit_clr  out  1  one-cycle pulse; integration drives unit reset = reset | unit_clr
- unit_valid  in  1  control unit in DONE
- unit_fault  in  1  control unit in ERROR
- sched_busy  out  1  state ≠ IDLE
- err_cnt  out  8  saturating count of fault and timeout completions

## Operation
- States: IDLE, START, WAIT, CLEAR. Moore outputs decoded from the state register.
- IDLE: when any req bit is set, the rr_arbiter picks a winner, searching from ptr+1 with wrap-around. The one-hot result is latched into grant, ptr is set to the winner index, and the FSM moves to START. When req = 0, the FSM stays in IDLE.
- START: unit_start = 1 for exactly one cycle. Timer is cleared to 0. Next state is WAIT.
- WAIT: timer increments each cycle. Resolution priority per cycle:
  - unit_fault → result ERR
  - else unit_valid → result OK
  - else timer == TIMEOUT-1 → result TMO
  - On any resolution, the FSM moves to CLEAR and the result is latched.
- CLEAR: unit_clr = 1 and cpl = grant. cpl_err = 1 for ERR, cpl_timeout = 1 for TMO, and both are 0 for OK. err_cnt increments on ERR or TMO and saturates at 255. grant clears on exit. Next state is IDLE.
- A requester dropping req mid-job has no effect: the job runs to completion and cpl still pulses.
- req re-asserted during CLEAR by the just-completed requester loses to any other pending requester, because ptr has advanced.
- Fairness: with all requesters pending, grants rotate 0,1,…,N_REQ-1,0.
- unit_valid and unit_fault are ignored outside WAIT.

## Timing
- Reset values:
  - state IDLE, ptr = N_REQ-1 (requester 0 wins first)
  - grant = 0, cpl = 0, cpl_err = 0, cpl_timeout = 0
  - unit_start = 0, unit_clr = 0, sched_busy = 0
  - err_cnt = 0, timer = 0
- Reset mid-operation aborts the job with no cpl pulse. The unit is reset by the shared reset.
- req sampled in IDLE at cycle t gives grant and unit_start at t+1. The unit enters INIT at t+2 and RUN at t+3.
- Unit status seen in WAIT at cycle s gives cpl and unit_clr at s+1. The next grant comes at s+3 at the earliest (IDLE at s+2).
- Minimum job period is 4 cycles plus the unit run time. The timeout job length is START + TIMEOUT WAIT cycles + CLEAR.

## Structure
- Package job_sched_pkg holds:
  - state enum (IDLE, START, WAIT, CLEAR)
  - result encoding (OK, ERR, TMO)
  - the err_cnt width constant
- Sub-module rr_arbiter: combinational; inputs req and ptr; outputs one-hot gnt and index; parameter N_REQ.
- The timer, err_cnt and FSM live in job_scheduler.

## Test plan
- **Single job:** reset; req=4'b0001; model unit asserts valid 5 cycles after start → grant=0001 one cycle after req; one unit_start pulse; cpl=0001 with cpl_err=0 and cpl_timeout=0; unit_clr pulse in the same cycle as cpl.
- **Round-robin:** req=4'b1111 held → grant order 0001, 0010, 0100, 1000, 0001; each cpl matches the preceding grant.
- **Fault:** model asserts fault → cpl_err=1, err_cnt=1; the next job proceeds after unit_clr.
- **Timeout:** TIMEOUT=8, unit never responds → cpl_timeout=1 exactly 8 WAIT cycles after START; err_cnt increments.
- **Simultaneous events:** valid and fault in the same cycle → cpl_err=1. valid on the timeout cycle → OK, not TMO.
- **Reset mid-WAIT:** all outputs return to reset values the next cycle with no cpl; after reset, req=1111 → grant=0001.
